// File: rtl/ps2_key_event_decoder.sv
// PS/2 Set-2 byte stream to key events: prefix FSM, shift/caps tracking, ASCII lookup
// and a show-ahead event FIFO with a valid/ready output handshake.
module ps2_key_event_decoder #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scancode,
  input  logic       valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] ev_ascii,
  output logic       shift_held,
  output logic       caps_lock,
  output logic       ev_overflow,
  input  logic       clr_ovf,
  output logic [1:0] dbg_state
);
  // Handshake: an event is transferred on every cycle where ev_valid && ev_ready;
  // ev_* hold the FIFO head and stay stable while ev_valid && !ev_ready.
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } ev_t;

  state_t          state, state_nx;
  logic [CW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            push, p_ext, p_brk;
  logic [7:0]      p_ascii;
  logic            lshift, rshift, caps_held;
  ev_t             mem [DEPTH];
  ev_t             head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, pop, wr;

  function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic ext,
                                          input logic upper);
    logic [4:0] li;
    logic       is_letter;
    logic [7:0] r;
    li        = '0;
    is_letter = 1'b1;
    r         = 8'h00;
    case (c)
      8'h1C: li = 5'd0;  8'h32: li = 5'd1;  8'h21: li = 5'd2;  8'h23: li = 5'd3;
      8'h24: li = 5'd4;  8'h2B: li = 5'd5;  8'h34: li = 5'd6;  8'h33: li = 5'd7;
      8'h43: li = 5'd8;  8'h3B: li = 5'd9;  8'h42: li = 5'd10; 8'h4B: li = 5'd11;
      8'h3A: li = 5'd12; 8'h31: li = 5'd13; 8'h44: li = 5'd14; 8'h4D: li = 5'd15;
      8'h15: li = 5'd16; 8'h2D: li = 5'd17; 8'h1B: li = 5'd18; 8'h2C: li = 5'd19;
      8'h3C: li = 5'd20; 8'h2A: li = 5'd21; 8'h1D: li = 5'd22; 8'h22: li = 5'd23;
      8'h35: li = 5'd24; 8'h1A: li = 5'd25;
      default: is_letter = 1'b0;
    endcase
    if (ext) begin
      r = (c == 8'h5A) ? 8'h0D : 8'h00;
    end else if (is_letter) begin
      r = (upper ? 8'h41 : 8'h61) + {3'b000, li};
    end else begin
      case (c)
        8'h45: r = 8'h30; 8'h16: r = 8'h31; 8'h1E: r = 8'h32; 8'h26: r = 8'h33;
        8'h25: r = 8'h34; 8'h2E: r = 8'h35; 8'h36: r = 8'h36; 8'h3D: r = 8'h37;
        8'h3E: r = 8'h38; 8'h46: r = 8'h39;
        8'h29: r = 8'h20; 8'h5A: r = 8'h0D; 8'h66: r = 8'h08;
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  assign tmo_hit   = (state != S_IDLE) && !valid && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_nx;
      if (valid || state == S_IDLE || tmo_hit) tmo_cnt <= '0;
      else                                     tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (valid) begin
      case (state)
        S_IDLE: begin
          if (scancode == 8'hE0)      state_nx = S_E0;
          else if (scancode == 8'hF0) state_nx = S_F0;
        end
        S_E0: begin
          if (scancode == 8'hF0)      state_nx = S_E0F0;
          else if (scancode != 8'hE0) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nx = S_IDLE;
    end
  end

  always_comb begin
    push  = 1'b0;
    p_ext = 1'b0;
    p_brk = 1'b0;
    if (valid) begin
      case (state)
        S_IDLE: begin
          // Receiver status/noise bytes never form an event.
          case (scancode)
            8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF, 8'hE1: push = 1'b0;
            default: push = 1'b1;
          endcase
        end
        S_E0: begin
          push  = (scancode != 8'hE0) && (scancode != 8'hF0);
          p_ext = 1'b1;
        end
        S_F0: begin
          push  = 1'b1;
          p_brk = 1'b1;
        end
        default: begin
          push  = 1'b1;
          p_ext = 1'b1;
          p_brk = 1'b1;
        end
      endcase
    end
    p_ascii = p_brk ? 8'h00 : ascii_of(scancode, p_ext, shift_held ^ caps_lock);
  end

  // Modifier state follows every decoded event, whether or not the FIFO had room.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_held <= 1'b0;
      caps_lock <= 1'b0;
    end else if (push && !p_ext) begin
      case (scancode)
        8'h12: lshift <= !p_brk;
        8'h59: rshift <= !p_brk;
        8'h58: begin
          if (!p_brk) begin
            if (!caps_held) caps_lock <= ~caps_lock;
            caps_held <= 1'b1;
          end else begin
            caps_held <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign shift_held = lshift | rshift;

  assign full     = (count == (AW+1)'(DEPTH));
  assign ev_valid = (count != '0);
  assign pop      = ev_valid && ev_ready;
  assign wr       = push && (!full || pop);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= '{code: scancode, ext: p_ext, brk: p_brk, ascii: p_ascii};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ev_overflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push && full && !pop) ev_overflow <= 1'b1;
      else if (clr_ovf)         ev_overflow <= 1'b0;
    end
  end

  assign ev_code  = ev_valid ? head.code  : 8'h00;
  assign ev_ext   = ev_valid ? head.ext   : 1'b0;
  assign ev_break = ev_valid ? head.brk   : 1'b0;
  assign ev_ascii = ev_valid ? head.ascii : 8'h00;
endmodule
